// File: rtl/data_mem_port.sv
// data_mem_port: byte/half/word load-store unit in front of a single-port synchronous 32-bit data RAM.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two RAM cycles; otherwise they return an error.
module data_mem_port #(
    parameter int RAM_WORD_ADDR_W = 14
) (
    input  logic                       SYS_clk,
    input  logic                       SYS_reset,
    input  logic                       MEM_req_valid,
    output logic                       MEM_req_ready,
    input  logic                       MEM_req_write,
    input  logic [1:0]                 MEM_req_length,
    input  logic                       MEM_req_signed,
    input  logic [31:0]                MEM_req_address,
    input  logic [31:0]                MEM_req_wdata,
    output logic                       MEM_resp_valid,
    output logic [31:0]                MEM_resp_rdata,
    output logic                       MEM_resp_error,
    output logic                       RAM_en,
    output logic [RAM_WORD_ADDR_W-1:0] RAM_addr,
    output logic [3:0]                 RAM_we,
    output logic [31:0]                RAM_wdata,
    input  logic [31:0]                RAM_rdata
);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, MERGE, ERR} state_t;
    state_t state, state_next;

    logic                       req_write;
    logic [1:0]                 req_length;
    logic                       req_signed;
    logic [1:0]                 req_off;
    logic [RAM_WORD_ADDR_W-1:0] req_word;
    logic [31:0]                req_wdata;
`ifdef MISALIGNED_SPLIT_EN
    logic                       req_split;
    logic [31:0]                word0;
`endif

    logic [2:0]  in_bytes;
    logic [2:0]  in_end;
    logic        in_split;
    logic        in_error;
    logic [3:0]  mask_n;
    logic [63:0] wd64;
    logic [7:0]  be8;
    logic [63:0] r64;
    logic [31:0] r_shift;
    logic [31:0] load_data;

    // The RAM aliases: address bits above the word address are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^MEM_req_address[31:RAM_WORD_ADDR_W+2];

    always_comb begin
        case (MEM_req_length)
            2'b01:   in_bytes = 3'd1;
            2'b10:   in_bytes = 3'd2;
            2'b11:   in_bytes = 3'd4;
            default: in_bytes = 3'd0;
        endcase
        in_end   = {1'b0, MEM_req_address[1:0]} + in_bytes;
        in_split = (in_end > 3'd4);
`ifdef MISALIGNED_SPLIT_EN
        in_error = (MEM_req_length == 2'b00);
`else
        in_error = (MEM_req_length == 2'b00) || in_split;
`endif
    end

    always_comb begin
        case (req_length)
            2'b01:   mask_n = 4'b0001;
            2'b10:   mask_n = 4'b0011;
            2'b11:   mask_n = 4'b1111;
            default: mask_n = 4'b0000;
        endcase
        wd64 = {32'b0, req_wdata} << {req_off, 3'b000};
        be8  = {4'b0, mask_n} << req_off;
    end

`ifndef MISALIGNED_SPLIT_EN
    logic unused_upper_lanes;
    assign unused_upper_lanes = ^{wd64[63:32], be8[7:4]};
`endif

    // In MERGE the last RAM word is on RAM_rdata; a split access pairs it with the word captured in ACC1.
    always_comb begin
`ifdef MISALIGNED_SPLIT_EN
        r64 = req_split ? {RAM_rdata, word0} : {32'b0, RAM_rdata};
`else
        r64 = {32'b0, RAM_rdata};
`endif
        r_shift = 32'(r64 >> {req_off, 3'b000});
        case (req_length)
            2'b01:   load_data = {{24{req_signed & r_shift[7]}}, r_shift[7:0]};
            2'b10:   load_data = {{16{req_signed & r_shift[15]}}, r_shift[15:0]};
            default: load_data = r_shift;
        endcase
    end

    always_comb begin
        state_next    = state;
        MEM_req_ready = 1'b0;
        RAM_en        = 1'b0;
        RAM_addr      = '0;
        RAM_we        = 4'b0000;
        RAM_wdata     = 32'b0;
        case (state)
            IDLE: begin
                MEM_req_ready = 1'b1;
                if (MEM_req_valid) begin
                    state_next = in_error ? ERR : ACC0;
                end
            end
            ACC0: begin
                RAM_en   = 1'b1;
                RAM_addr = req_word;
                if (req_write) begin
                    RAM_we    = be8[3:0];
                    RAM_wdata = wd64[31:0];
                end
`ifdef MISALIGNED_SPLIT_EN
                state_next = req_split ? ACC1 : MERGE;
`else
                state_next = MERGE;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            ACC1: begin
                RAM_en   = 1'b1;
                RAM_addr = req_word + RAM_WORD_ADDR_W'(1);
                if (req_write) begin
                    RAM_we    = be8[7:4];
                    RAM_wdata = wd64[63:32];
                end
                state_next = MERGE;
            end
`endif
            MERGE:   state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            state          <= IDLE;
            MEM_resp_valid <= 1'b0;
            MEM_resp_rdata <= 32'b0;
            MEM_resp_error <= 1'b0;
            req_write      <= 1'b0;
            req_length     <= 2'b00;
            req_signed     <= 1'b0;
            req_off        <= 2'b00;
            req_word       <= '0;
            req_wdata      <= 32'b0;
`ifdef MISALIGNED_SPLIT_EN
            req_split      <= 1'b0;
            word0          <= 32'b0;
`endif
        end else begin
            state          <= state_next;
            MEM_resp_valid <= 1'b0;
            MEM_resp_error <= 1'b0;
            if (MEM_req_valid && MEM_req_ready) begin
                req_write  <= MEM_req_write;
                req_length <= MEM_req_length;
                req_signed <= MEM_req_signed;
                req_off    <= MEM_req_address[1:0];
                req_word   <= MEM_req_address[RAM_WORD_ADDR_W+1:2];
                req_wdata  <= MEM_req_wdata;
`ifdef MISALIGNED_SPLIT_EN
                req_split  <= in_split;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            if (state == ACC1) begin
                word0 <= RAM_rdata;
            end
`endif
            if (state == MERGE) begin
                MEM_resp_valid <= 1'b1;
                MEM_resp_rdata <= req_write ? 32'b0 : load_data;
            end
            if (state == ERR) begin
                MEM_resp_valid <= 1'b1;
                MEM_resp_error <= 1'b1;
                MEM_resp_rdata <= 32'b0;
            end
        end
    end

endmodule
